// File: rtl/sfx_scheduler.sv
// rtl/sfx_scheduler.sv - fixed-priority sound-effect scheduler sharing one sample ROM and the codec sample path
module sfx_scheduler #(
    parameter int NUM_SRC = 4,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 16,
    localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        trigger,
    input  logic [NUM_SRC*ADDR_W-1:0] clip_base,
    input  logic [NUM_SRC*ADDR_W-1:0] clip_len,
    input  logic                      sample_req,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic                      rom_rd,
    input  logic [DATA_W-1:0]         rom_rdata,
    output logic [DATA_W-1:0]         audio_output,
    output logic                      busy,
    output logic [SRC_W-1:0]          active_src,
    output logic                      done
);

    // IDLE: nothing playing; PLAY: clip loaded, waiting for a codec request;
    // REQ: ROM read strobe cycle; WAIT: ROM data arrives and is latched.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_REQ  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t              state_q;
    logic [NUM_SRC-1:0]  trig_q;
    logic [NUM_SRC-1:0]  pending_q;
    logic [NUM_SRC-1:0]  pending_d;
    logic [NUM_SRC-1:0]  rise;
    logic [NUM_SRC-1:0]  sel_onehot;
    logic [SRC_W-1:0]    sel_idx;
    logic                sel_found;
    logic                load_en;
    logic [ADDR_W-1:0]   base_a [NUM_SRC];
    logic [ADDR_W-1:0]   len_a  [NUM_SRC];
    logic [ADDR_W-1:0]   sel_base;
    logic [ADDR_W-1:0]   sel_len;

    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   remain_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic                rom_rd_q;
    logic [DATA_W-1:0]   audio_q;
    logic                busy_q;
    logic [SRC_W-1:0]    active_q;
    logic                done_q;

    // Unpack the per-source clip descriptors into arrays for indexed selection.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            base_a[i] = clip_base[i*ADDR_W +: ADDR_W];
            len_a[i]  = clip_len[i*ADDR_W +: ADDR_W];
        end
    end

    // Fixed priority: the lowest-index pending source wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = SRC_W'(i);
            end
        end
        sel_onehot = pending_q & (~pending_q + NUM_SRC'(1));
        sel_base   = base_a[sel_idx];
        sel_len    = len_a[sel_idx];
    end

    // A load happens whenever IDLE sees a request, or PLAY sees an equal or
    // higher priority request (restart or preempt). A new rise always survives
    // the clear of the bit being loaded in the same cycle.
    always_comb begin
        rise      = trigger & ~trig_q;
        load_en   = sel_found &&
                    ((state_q == S_IDLE) || ((state_q == S_PLAY) && (sel_idx <= active_q)));
        pending_d = (pending_q & ~(load_en ? sel_onehot : '0)) | rise;
    end

    // Trigger history follows the pins even during reset, so a level held
    // through reset is not mistaken for a fresh edge once reset releases.
    always_ff @(posedge clk) begin
        trig_q <= trigger;
    end

    // Pending request bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Playback FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            rom_addr_q <= '0;
            rom_rd_q   <= 1'b0;
            audio_q    <= '0;
            busy_q     <= 1'b0;
            active_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            rom_rd_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_en) begin
                        // A zero-length clip is simply dropped.
                        if (sel_len != '0) begin
                            addr_q   <= sel_base;
                            remain_q <= sel_len;
                            active_q <= sel_idx;
                            busy_q   <= 1'b1;
                            state_q  <= S_PLAY;
                        end
                    end else if (sample_req) begin
                        audio_q <= '0;
                    end
                end
                S_PLAY: begin
                    if (load_en) begin
                        // Aborted clip ends silently; a zero-length newcomer
                        // is discarded and the current clip carries on.
                        if (sel_len != '0) begin
                            addr_q   <= sel_base;
                            remain_q <= sel_len;
                            active_q <= sel_idx;
                        end
                    end else if (sample_req) begin
                        rom_rd_q   <= 1'b1;
                        rom_addr_q <= addr_q;
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    audio_q  <= rom_rdata;
                    addr_q   <= addr_q + ADDR_W'(1);
                    remain_q <= remain_q - ADDR_W'(1);
                    if (remain_q == ADDR_W'(1)) begin
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        active_q <= '0;
                        state_q  <= S_IDLE;
                    end else begin
                        state_q  <= S_PLAY;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr     = rom_addr_q;
    assign rom_rd       = rom_rd_q;
    assign audio_output = audio_q;
    assign busy         = busy_q;
    assign active_src   = active_q;
    assign done         = done_q;

endmodule
